// File: rtl/polyvec_wr_arbiter.sv
// polyvec_wr_arbiter: round-robin arbiter merging two polyvec write-burst requesters onto one BRAM write port.
// Latency: gnt 1 cycle after req; accepted beat appears on bram_* 1 cycle later; burst_done 1 cycle after last write.
// Backpressure: none on beats (the granted requester streams freely); requests are level and wait for the current burst.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   req0/req1                    burst requests (0 = enc pk path, 1 = dec sk path), held until granted
//   vld0/1, waddr0/1, wdata0/1   write beats from each requester; only the granted one is accepted
//   gnt0/gnt1                    registered one-hot grant
//   bram_we/bram_waddr/wdata     registered shared BRAM write port
//   burst_done, burst_src        completion pulse and index of last completed burst
//   err_seq                      sticky beat-address sequence error
//   err_timeout                  watchdog abort pulse
// Optional feature: define POLYVEC_ARB_WDOG_EN to enable the BUSY idle watchdog.

module polyvec_wr_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 128,
    parameter int BURST_LEN = 64,
    parameter int WDOG_CYC  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              vld0,
    input  logic              vld1,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_waddr,
    output logic [DATA_W-1:0] bram_wdata,
    output logic              burst_done,
    output logic              burst_src,
    output logic              err_seq,
    output logic              err_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(BURST_LEN);

    state_t            state_q, state_d;
    logic              gnt0_d, gnt1_d;
    logic              src_q, src_d;      // requester owning the current burst
    logic              ptr_q, ptr_d;      // last requester granted (round-robin pointer)
    logic [ADDR_W:0]   cnt_q, cnt_d;      // accepted beats in current burst
    logic              bram_we_d;
    logic [ADDR_W-1:0] bram_waddr_d;
    logic [DATA_W-1:0] bram_wdata_d;
    logic              burst_done_d;
    logic              burst_src_d;
    logic              err_seq_d;

    logic              pick;
    logic              beat_vld;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] beat_data;
    logic [ADDR_W:0]   cnt_inc;

`ifdef POLYVEC_ARB_WDOG_EN
    localparam int             WDOG_W    = $clog2(WDOG_CYC + 1);
    localparam logic [WDOG_W-1:0] IDLE_ONE  = WDOG_W'(1);
    localparam logic [WDOG_W-1:0] IDLE_LAST = WDOG_W'(WDOG_CYC - 1);

    logic [WDOG_W-1:0] idle_q, idle_d;
    logic              err_timeout_q, err_timeout_d;

    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    // On a tie the requester not granted last wins; otherwise whoever is asking.
    assign pick      = (req0 && req1) ? ~ptr_q : req1;

    // Only the owning requester's beats count; gnt already implies BUSY, the state term is belt and braces.
    assign beat_vld  = (state_q == BUSY) && (src_q ? (gnt1 && vld1) : (gnt0 && vld0));
    assign beat_addr = src_q ? waddr1 : waddr0;
    assign beat_data = src_q ? wdata1 : wdata0;
    assign cnt_inc   = cnt_q + CNT_ONE;

    always_comb begin
        state_d      = state_q;
        gnt0_d       = gnt0;
        gnt1_d       = gnt1;
        src_d        = src_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        bram_we_d    = 1'b0;
        bram_waddr_d = bram_waddr;
        bram_wdata_d = bram_wdata;
        burst_done_d = 1'b0;
        burst_src_d  = burst_src;
        err_seq_d    = err_seq;
`ifdef POLYVEC_ARB_WDOG_EN
        idle_d        = idle_q;
        err_timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    src_d   = pick;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef POLYVEC_ARB_WDOG_EN
                    idle_d  = '0;
`endif
                end
            end
            BUSY: begin
                if (beat_vld) begin
                    bram_we_d    = 1'b1;
                    bram_waddr_d = beat_addr;
                    bram_wdata_d = beat_data;
                    cnt_d        = cnt_inc;
                    // Out-of-order beat is still written; only flagged.
                    if (beat_addr != cnt_q[ADDR_W-1:0]) begin
                        err_seq_d = 1'b1;
                    end
                    if (cnt_inc == CNT_LAST) begin
                        gnt0_d  = 1'b0;
                        gnt1_d  = 1'b0;
                        state_d = DONE;
                    end
`ifdef POLYVEC_ARB_WDOG_EN
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    // This idle cycle is the WDOG_CYC-th in a row: abort the burst.
                    err_timeout_d = 1'b1;
                    gnt0_d        = 1'b0;
                    gnt1_d        = 1'b0;
                    ptr_d         = src_q;
                    state_d       = IDLE;
                end else begin
                    idle_d = idle_q + IDLE_ONE;
`endif
                end
            end
            DONE: begin
                burst_done_d = 1'b1;
                burst_src_d  = src_q;
                ptr_d        = src_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            src_q      <= 1'b0;
            ptr_q      <= 1'b1;
            cnt_q      <= '0;
            bram_we    <= 1'b0;
            bram_waddr <= '0;
            bram_wdata <= '0;
            burst_done <= 1'b0;
            burst_src  <= 1'b0;
            err_seq    <= 1'b0;
`ifdef POLYVEC_ARB_WDOG_EN
            idle_q        <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt0       <= gnt0_d;
            gnt1       <= gnt1_d;
            src_q      <= src_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            bram_we    <= bram_we_d;
            bram_waddr <= bram_waddr_d;
            bram_wdata <= bram_wdata_d;
            burst_done <= burst_done_d;
            burst_src  <= burst_src_d;
            err_seq    <= err_seq_d;
`ifdef POLYVEC_ARB_WDOG_EN
            idle_q        <= idle_d;
            err_timeout_q <= err_timeout_d;
`endif
        end
    end

endmodule
